// File: rtl/pong_ball_engine.sv
// Pong ball/score engine: advances ball position, bounces, scoring and game
// state once per video frame; every output is a register for the renderer.
module pong_ball_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int SPEED        = 2,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_MAX    = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] padl_y,
  input  logic [9:0] padr_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_valid,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int CW = $clog2(PAUSE_FRAMES + 1);

  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] BSZ   = 11'(BALL_SIZE);
  localparam logic [10:0] PH    = 11'(PAD_H);
  localparam logic [10:0] L_FACE = 11'(PAD_L_X + PAD_W);
  localparam logic [10:0] R_FACE = 11'(PAD_R_X);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  CX    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  CY    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [3:0]  SMAX  = 4'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

  state_t        state, state_d;
  logic [9:0]    x_d, y_d;
  logic          dx, dx_d, dy, dy_d;
  logic [3:0]    sl_d, sr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          valid_d, over_d;

  // Candidate motion for this frame, all in 11 bits so nothing wraps.
  logic [10:0] x11, y11, pl11, pr11, nx, ny, ny_w;
  logic        dy_w, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  always_comb begin
    x11  = {1'b0, ball_x};
    y11  = {1'b0, ball_y};
    pl11 = {1'b0, padl_y};
    pr11 = {1'b0, padr_y};
    nx   = dx ? x11 + SPD : x11 - SPD;
    ny   = dy ? y11 + SPD : y11 - SPD;

    ny_w = ny;
    dy_w = dy;
    if (dy && (ny + BSZ >= 11'(V_ACTIVE))) begin
      ny_w = Y_MAX;
      dy_w = 1'b0;
    end else if (!dy && (y11 < SPD)) begin
      ny_w = '0;
      dy_w = 1'b1;
    end

    ovl_l  = (y11 + BSZ > pl11) && (y11 < pl11 + PH);
    ovl_r  = (y11 + BSZ > pr11) && (y11 < pr11 + PH);
    // Requiring the ball to start on the near side of a face means a ball
    // that has already slipped past a paddle is never caught.
    hit_l  = !dx && (x11 >= L_FACE) && (nx <= L_FACE) && ovl_l;
    hit_r  = dx && (x11 + BSZ <= R_FACE) && (nx + BSZ >= R_FACE) && ovl_r;
    miss_l = !dx && (x11 < SPD);
    miss_r = dx && (nx > X_MAX);
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold value first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d = state;
    x_d     = ball_x;
    y_d     = ball_y;
    dx_d    = dx;
    dy_d    = dy;
    sl_d    = score_l;
    sr_d    = score_r;
    cnt_d   = cnt;
    valid_d = ball_valid;
    over_d  = game_over;

    unique case (state)
      IDLE: if (serve) state_d = PLAY;

      PLAY: if (frame_tick) begin
        dy_d = dy_w;
        if (miss_l || miss_r) begin
          if (miss_l) begin
            sr_d = (score_r == SMAX) ? score_r : score_r + 4'd1;
            dx_d = 1'b0;
          end else begin
            sl_d = (score_l == SMAX) ? score_l : score_l + 4'd1;
            dx_d = 1'b1;
          end
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = SCORED;
        end else begin
          y_d = ny_w[9:0];
          if (hit_l) begin
            x_d  = L_FACE[9:0];
            dx_d = 1'b1;
          end else if (hit_r) begin
            x_d  = 10'(R_FACE - BSZ);
            dx_d = 1'b0;
          end else begin
            x_d = nx[9:0];
          end
        end
      end

      SCORED: if (frame_tick) begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(PAUSE_FRAMES - 1)) begin
          if ((score_l == SMAX) || (score_r == SMAX)) begin
            over_d  = 1'b1;
            state_d = OVER;
          end else begin
            x_d     = CX;
            y_d     = CY;
            valid_d = 1'b1;
            state_d = PLAY;
          end
        end
      end

      OVER: if (serve) begin
        sl_d    = '0;
        sr_d    = '0;
        x_d     = CX;
        y_d     = CY;
        dx_d    = 1'b1;
        dy_d    = 1'b1;
        valid_d = 1'b1;
        over_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      ball_x     <= CX;
      ball_y     <= CY;
      dx         <= 1'b1;
      dy         <= 1'b1;
      score_l    <= '0;
      score_r    <= '0;
      cnt        <= '0;
      ball_valid <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      ball_x     <= x_d;
      ball_y     <= y_d;
      dx         <= dx_d;
      dy         <= dy_d;
      score_l    <= sl_d;
      score_r    <= sr_d;
      cnt        <= cnt_d;
      ball_valid <= valid_d;
      game_over  <= over_d;
    end
  end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Frame-rate game engine for FPGA Pong. It holds the ball position, direction, per-player scores and game state, and advances them once per video frame. It sits directly upstream of the VGA 640x480 renderer, which draws from `ball_x`, `ball_y` and `ball_valid`. The scores also feed the 7-segment display controller.

## Interface
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels (square ball).
- `PAD_W`, 8: paddle width.
- `PAD_H`, 64: paddle height.
- `PAD_L_X`, 16: left paddle left edge x.
- `PAD_R_X`, 616: right paddle left edge x (this is its hitting face).
- `SPEED`, 2: pixels moved per frame on each axis.
- `PAUSE_FRAMES`, 60: frames the ball stays hidden after a point.
- `SCORE_MAX`, 9: score that ends the game.

- `clk` in 1: system clock; the only clock.
- `clr` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per frame, at start of vertical blanking.
- `serve` in 1: one-cycle pulse, already synchronized and debounced.
- `padl_y` in 10: left paddle top edge y, 0..V_ACTIVE-PAD_H.
- `padr_y` in 10: right paddle top edge y, 0..V_ACTIVE-PAD_H.
- `ball_x` out 10: ball left edge x.
- `ball_y` out 10: ball top edge y.
- `ball_valid` out 1: renderer draws the ball when high.
- `score_l` out 4: left player score.
- `score_r` out 4: right player score.
- `game_over` out 1: high when a player has reached SCORE_MAX.

## Operation
- States:
  - IDLE: ball centred, waiting for a serve.
  - PLAY: ball moving.
  - SCORED: pause after a point.
  - OVER: game finished.
- Centre position: CX=(H_ACTIVE-BALL_SIZE)/2=316, CY=(V_ACTIVE-BALL_SIZE)/2=236.
- Direction bits: `dx` (1=right), `dy` (1=down).
- Reset values:
  - State IDLE.
  - `ball_x`=316, `ball_y`=236.
  - `dx`=1, `dy`=1.
  - Scores 0, `game_over`=0, `ball_valid`=1.
  - Pause counter 0.
- IDLE:
  - `serve` moves to PLAY.
  - The ball does not move on a `frame_tick` in the same cycle; motion starts on the next tick.
  - `frame_tick` alone does nothing.
- PLAY, on each `frame_tick`, with nx=x±SPEED and ny=y±SPEED according to `dx`/`dy`:
  - Bottom wall: if `dy`=1 and ny+BALL_SIZE≥V_ACTIVE, set ny=V_ACTIVE-BALL_SIZE and `dy`=0.
  - Top wall: if `dy`=0 and y<SPEED, set ny=0 and `dy`=1.
  - Left paddle: hit when all of the following hold. Then nx=PAD_L_X+PAD_W and `dx`=1.
    - `dx`=0.
    - x≥PAD_L_X+PAD_W.
    - nx≤PAD_L_X+PAD_W.
    - Current y overlaps the paddle: y+BALL_SIZE>`padl_y` and y<`padl_y`+PAD_H.
  - Right paddle: mirrored. Hit when `dx`=1, x+BALL_SIZE≤PAD_R_X, nx+BALL_SIZE≥PAD_R_X, and current y overlaps `padr_y`. Then nx=PAD_R_X-BALL_SIZE and `dx`=0.
  - A ball already past a paddle face is never caught and continues to the edge.
  - Left miss: `dx`=0 and x<SPEED. `score_r` increments; `dx` is set to 0 (serve goes toward the loser).
  - Right miss: `dx`=1 and nx>H_ACTIVE-BALL_SIZE. `score_l` increments; `dx` is set to 1.
  - On either miss: position is held, `ball_valid`=0, pause counter clears, state moves to SCORED.
  - A wall bounce and a paddle or miss event in the same frame are both applied.
- SCORED:
  - Each `frame_tick` increments the pause counter.
  - On the PAUSE_FRAMES-th tick: if either score equals SCORE_MAX, go to OVER. Otherwise ball goes to centre, `ball_valid`=1, and state returns to PLAY (auto-serve, `dy` unchanged).
- OVER:
  - `game_over`=1, `ball_valid`=0.
  - `serve` clears both scores, centres the ball, sets `dx`=1 and `dy`=1, and moves to IDLE.
- `serve` is ignored in PLAY and SCORED.
- Scores saturate at SCORE_MAX.
- All arithmetic is 11-bit so nx and ny cannot wrap.

## Timing
- Every output is registered and updates in the cycle after the `frame_tick` (or `serve`) that caused it.
- Outputs are stable for the rest of the frame; the renderer samples them during active video.
- `clr` low clears all state immediately, at any point, including mid-PLAY or mid-pause. After release, the first active edge behaves as IDLE.
- A `frame_tick` that coincides with an OVER→IDLE `serve` is ignored.

## Test plan
- Reset, then 3 `frame_tick`s with no `serve` -> `ball_x`=316, `ball_y`=236, `ball_valid`=1, scores 0.
- `serve`, then 1 tick -> (318,238).
- `serve`, then 118 ticks -> `ball_y`=472. Tick 119 -> `ball_y`=470, `ball_x`=554 (bottom bounce).
- `padr_y`=400, `serve`, then 146 ticks -> `ball_x`=608. Tick 147 -> `ball_x`=606 (paddle return).
- `padr_y`=0 and `padl_y`=0, `serve`:
  - 159 ticks -> `score_l`=1, `ball_valid`=0.
  - 60 more ticks -> (316,236), `ball_valid`=1, ball moving right.
- Let 9 right misses occur (SCORE_MAX=9) -> `game_over`=1 after the final pause.
  - `serve` -> scores 0, IDLE.
  - Assert `clr` during PLAY -> outputs return to reset values within the same cycle.
